// File: rtl/uart_tx_cfg.sv
// UART transmitter with a runtime-selectable frame: 5..DATA_W data bits, optional
// even/odd parity and one or two stop bits, paced by an oversampling baud tick.
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bd_tick,
    input  logic              i_tx_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_data_bits,
    input  logic [1:0]        i_parity,
    input  logic              i_stop2,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic              o_tx_done
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        MAX_BITS  = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [3:0]          r_bit_cnt;
    logic [3:0]          r_last_bit;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par_en;
    logic                r_par_val;
    logic                r_stop2;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic [3:0]          w_eff_bits;
    logic [DATA_W-1:0]   w_mask;
    logic                w_par_en;
    logic                w_par_val;
    logic                w_bit_end;

    // Parity is resolved at acceptance from the masked character, so the
    // shift register never needs to be re-scanned later in the frame.
    always_comb begin
        w_eff_bits = ((i_data_bits >= 4'd5) && (i_data_bits <= MAX_BITS)) ? i_data_bits : MAX_BITS;
        w_mask     = {DATA_W{1'b1}} >> (DATA_W - int'(w_eff_bits));
        w_par_en   = (i_parity == 2'b01) || (i_parity == 2'b10);
        w_par_val  = (^(i_data & w_mask)) ^ (i_parity == 2'b10);
        w_bit_end  = i_bd_tick && (r_tick == TICK_LAST);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit_cnt  <= '0;
            r_last_bit <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_val  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && i_bd_tick) begin
                r_tick <= w_bit_end ? '0 : r_tick + TICK_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_tx_start) begin
                        r_shift    <= i_data;
                        r_last_bit <= w_eff_bits - 4'd1;
                        r_par_en   <= w_par_en;
                        r_par_val  <= w_par_val;
                        r_stop2    <= i_stop2;
                        r_tick     <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == r_last_bit) begin
                            r_bit_cnt <= '0;
                            r_tx      <= r_par_en ? r_par_val : 1'b1;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // The bit counter is reused to count the second stop period.
                    if (w_bit_end) begin
                        if (r_stop2 && (r_bit_cnt == 4'd0)) begin
                            r_bit_cnt <= 4'd1;
                        end else begin
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b1;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus pushes whole expected frames built from
// the frame-format rules, and a monitor pops and checks them as the line plays them out.
module tb_uart_tx_cfg;

    localparam int DATA_W = 8;
    localparam int OS     = 16;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       bdTick   = 1'b0;
    logic       txStart  = 1'b0;
    logic [7:0] data     = 8'h00;
    logic [3:0] dataBits = 4'd8;
    logic [1:0] parity   = 2'b00;
    logic       stop2    = 1'b0;
    logic       tx;
    logic       txBusy;
    logic       txDone;

    int   checks     = 0;
    int   errors     = 0;
    int   tickPeriod = 4;
    bit   tickStall  = 1'b0;
    logic monTick    = 1'b0;
    int   framesSent = 0;
    int   framesDone = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } frameT;

    frameT expQ[$];
    frameT cur;

    always #5 clock = ~clock;

    uart_tx_cfg #(.DATA_W(DATA_W), .OVERSAMPLE(OS)) dut (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_bd_tick   (bdTick),
        .i_tx_start  (txStart),
        .i_data      (data),
        .i_data_bits (dataBits),
        .i_parity    (parity),
        .i_stop2     (stop2),
        .o_tx        (tx),
        .o_tx_busy   (txBusy),
        .o_tx_done   (txDone)
    );

    // Baud tick source: one pulse every tickPeriod clocks, silenced while stalled.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            cnt++;
            if (!tickStall && (cnt >= tickPeriod)) begin
                bdTick = 1'b1;
                cnt    = 0;
            end else begin
                bdTick = 1'b0;
            end
        end
    end

    always @(posedge clock) monTick <= bdTick;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: the list of line levels, one entry per bit period.
    function automatic frameT buildFrame(input logic [7:0] d, input logic [3:0] b,
                                         input logic [1:0] p, input logic s);
        frameT f;
        int n;
        int ones;
        int idx;
        n      = (b >= 5 && b <= DATA_W) ? int'(b) : DATA_W;
        ones   = 0;
        f.bits = '0;
        f.bits[0] = 1'b0;
        idx    = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[idx] = d[i];
            if (d[i]) ones++;
            idx++;
        end
        if (p == 2'b01) begin
            f.bits[idx] = ((ones % 2) == 1);
            idx++;
        end else if (p == 2'b10) begin
            f.bits[idx] = ((ones % 2) == 0);
            idx++;
        end
        f.bits[idx] = 1'b1;
        idx++;
        if (s) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.nbits = idx;
        return f;
    endfunction

    // Monitor: counts ticks from the start edge, checks each bit mid-period and the frame end.
    initial begin
        bit inFrame;
        bit waitIdle;
        int ticks;
        inFrame  = 1'b0;
        waitIdle = 1'b0;
        ticks    = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                inFrame  = 1'b0;
                waitIdle = 1'b0;
            end else begin
                if (txDone && !(inFrame && !txBusy)) checkOutput("spuriousDone", int'(txDone), 0);
                if (waitIdle) begin
                    if (!txBusy) waitIdle = 1'b0;
                end else if (inFrame) begin
                    if (monTick) ticks++;
                    if (!txBusy) begin
                        checkOutput("frameTicks", ticks, cur.nbits * OS);
                        checkOutput("doneAtEnd", int'(txDone), 1);
                        checkOutput("idleLevel", int'(tx), 1);
                        inFrame = 1'b0;
                        framesDone++;
                    end else if (ticks >= cur.nbits * OS) begin
                        checkOutput("frameOverrun", ticks, cur.nbits * OS - 1);
                        inFrame  = 1'b0;
                        waitIdle = 1'b1;
                    end else if (monTick && (ticks % OS) == OS / 2) begin
                        checkOutput($sformatf("bit%0d", ticks / OS), int'(tx), int'(cur.bits[ticks / OS]));
                    end
                end else if (txBusy) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", 1, 0);
                        waitIdle = 1'b1;
                    end else begin
                        cur     = expQ.pop_front();
                        inFrame = 1'b1;
                        ticks   = 0;
                        checkOutput("startLevel", int'(tx), 0);
                    end
                end
            end
        end
    end

    task automatic launch(input logic [7:0] d, input logic [3:0] b, input logic [1:0] p, input logic s);
        data     = d;
        dataBits = b;
        parity   = p;
        stop2    = s;
        txStart  = 1'b1;
        expQ.push_back(buildFrame(d, b, p, s));
        framesSent++;
        @(negedge clock);
        txStart = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] b, input logic [1:0] p, input logic s);
        int guard;
        guard = 0;
        @(negedge clock);
        while (txBusy && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        if (txBusy) checkOutput("idleTimeout", 1, 0);
        launch(d, b, p, s);
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (!txDone && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        if (!txDone) checkOutput("doneTimeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("resetTx", int'(tx), 1);
        checkOutput("resetBusy", int'(txBusy), 0);
        checkOutput("resetDone", int'(txDone), 0);
        reset = 1'b0;

        tickPeriod = 4;
        applyStimulus(8'hA5, 4'd8, 2'b00, 1'b0);
        waitDone();
        applyStimulus(8'hC1, 4'd7, 2'b01, 1'b1);
        waitDone();
        applyStimulus(8'h1F, 4'd5, 2'b10, 1'b0);
        waitDone();
        applyStimulus(8'hA5, 4'd12, 2'b00, 1'b0);
        waitDone();

        // Config and a stray start change mid-frame; the frame must not notice.
        applyStimulus(8'h96, 4'd8, 2'b01, 1'b0);
        repeat (300) @(negedge clock);
        data     = 8'hFF;
        parity   = 2'b10;
        stop2    = 1'b1;
        dataBits = 4'd5;
        txStart  = 1'b1;
        @(negedge clock);
        txStart  = 1'b0;
        waitDone();

        applyStimulus(8'h5A, 4'd8, 2'b00, 1'b0);
        waitDone();
        launch(8'h3C, 4'd8, 2'b00, 1'b0);
        checkOutput("b2bBusy", int'(txBusy), 1);
        checkOutput("b2bLow", int'(tx), 0);
        waitDone();

        // Asynchronous reset during the 4th data bit abandons the frame.
        applyStimulus(8'hE7, 4'd8, 2'b00, 1'b0);
        repeat (288) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checkOutput("midResetTx", int'(tx), 1);
        checkOutput("midResetBusy", int'(txBusy), 0);
        checkOutput("midResetDone", int'(txDone), 0);
        expQ.delete();
        framesSent--;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        applyStimulus(8'h55, 4'd8, 2'b00, 1'b0);
        waitDone();

        for (int i = 0; i < 12; i++) begin
            tickPeriod = $urandom_range(1, 5);
            applyStimulus(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (i == 3) begin
                repeat (100) @(negedge clock);
                tickStall = 1'b1;
                repeat (150) @(negedge clock);
                tickStall = 1'b0;
            end
            waitDone();
        end

        repeat (20) @(negedge clock);
        checkOutput("framesDone", framesDone, framesSent);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter that serialises one character per request. Frame format is start bit, 5–`DATA_W` data bits LSB first, optional even/odd parity, then 1 or 2 stop bits. It is driven by the shared baud-rate generator's oversampling tick and replaces the fixed 8N1 transmitter wherever the frame format must be set by software or by the host-interface FSM.

## Interface
- `DATA_W`, default 8: maximum data bits per frame; legal range 5–9.
- `OVERSAMPLE`, default 16: baud ticks per bit period; must be ≥ 2.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_bd_tick`  in  1  one-cycle oversampling tick from the baud generator.
- `i_tx_start`  in  1  start request; honoured only in IDLE.
- `i_data`  in  `DATA_W`  character; bit 0 is sent first.
- `i_data_bits`  in  4  data bits per frame; values outside 5..`DATA_W` are treated as `DATA_W`.
- `i_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- `i_stop2`  in  1  0 selects one stop bit, 1 selects two.
- `o_tx`  out  1  serial line; registered; idles high.
- `o_tx_busy`  out  1  high from the cycle after an accepted start until the frame ends.
- `o_tx_done`  out  1  one-cycle pulse at frame end.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Per-state line level:**
  - IDLE: `o_tx` = 1.
  - START: `o_tx` = 0.
  - DATA: `o_tx` = shift register bit 0.
  - PARITY: `o_tx` = computed parity.
  - STOP: `o_tx` = 1.
- **Start acceptance:** in IDLE with `i_tx_start` = 1, latch `i_data`, the effective data-bit count, `i_parity` and `i_stop2` into internal registers. Clear the tick and bit counters. Go to START.
- **Config changes:** changes on the config or data inputs after acceptance have no effect on the frame in flight.
- **Tick counter:** width $clog2(`OVERSAMPLE`). It advances only on `i_bd_tick`. A bit period ends on the tick where the counter equals `OVERSAMPLE`-1; the counter then wraps to 0.
- **START:** after one bit period, go to DATA.
- **DATA:** at the end of each bit period, shift the data register right and increment the bit counter. After the last configured bit, go to PARITY if parity is enabled, otherwise go to STOP.
- **Parity value:** computed over the latched data bits actually sent; bits above the configured count are masked.
  - Even mode: parity = XOR of the sent bits (total count of 1s, including parity, is even).
  - Odd mode: parity = inverted XOR.
- **PARITY:** one bit period, then go to STOP.
- **STOP:** lasts `OVERSAMPLE` ticks, or 2×`OVERSAMPLE` ticks when `i_stop2` was latched high. On the final tick, go to IDLE.
- **Ignored starts:** `i_tx_start` outside IDLE is ignored; it is not queued.

## Timing
- **Reset values:** `o_tx` = 1, `o_tx_busy` = 0, `o_tx_done` = 0, state = IDLE; all counters and the shift register are 0. Reset takes effect immediately, including mid-frame, and the line returns high without completing the frame.
- **Start latency:** `i_tx_start` is sampled at edge N; `o_tx` falls and `o_tx_busy` rises in cycle N+1.
- **Bit boundaries:** they fall on the clock edge that samples the terminating `i_bd_tick`. `o_tx` shows the new bit level from the following cycle.
- **Frame length in ticks:** (1 + data bits + parity enabled + stop bits) × `OVERSAMPLE`.
- **Frame end:** on the final stop tick edge, the state becomes IDLE and `o_tx_busy` drops. `o_tx_done` is high for exactly that first IDLE cycle.
- **Back-to-back frames:** a start asserted during the `o_tx_done` cycle is accepted, so consecutive frames have no idle gap beyond one clock.
- **Stalled ticks:** with `i_bd_tick` held low, the FSM holds its state and `o_tx` holds its level indefinitely.

## Test plan
- **8N1:** `OVERSAMPLE`=16, tick every 4 clocks, `i_data`=0xA5, bits=8, parity=00, stop2=0 -> line 0,1,0,1,0,0,1,0,1,1. Each bit lasts 16 ticks; total 160 ticks; exactly one `o_tx_done` pulse.
- **7E2:** `i_data`=0xC1, bits=7, parity=01, stop2=1 -> data 1,0,0,0,0,0,1, parity 0 (bit 7 masked), then two stop bits; total 176 ticks.
- **5O1 and clamp:** `i_data`=0x1F, bits=5, parity=10 -> parity bit 0. Then bits=12 with 8N1 settings -> frame identical to bits=8.
- **Latched config:** change `i_data`, `i_parity` and `i_stop2` mid-frame and pulse `i_tx_start` during DATA -> frame unchanged, no second frame started.
- **Back-to-back:** assert `i_tx_start` in the `o_tx_done` cycle with 0x3C -> `o_tx` goes low in the next cycle and the second frame is correct.
- **Reset mid-frame:** assert `i_reset` asynchronously during the 4th data bit -> `o_tx`=1, busy=0, done=0 immediately. After release, a 0x55 frame is sent correctly.
